irq_front_end: RTL and testbench

Conditions the three external interrupt buttons before they reach the interrupt controller in the WB stage. Each raw, asynchronous, bouncy input is synchronised, debounced and edge-detected into a clean one-cycle press pulse. The pulse drives the controller's break inputs. A per-source pending level is held until the controller acknowledges it, and presses lost while a request is already pending are flagged.

---
 rtl/irq_front_pkg.sv | 15 +
 rtl/irq_debounce.sv | 83 ++++++++
 rtl/irq_front_end.sv | 61 ++++++
 tb/tb_irq_front_end.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_front_pkg.sv
// rtl/irq_front_pkg.sv - shared defaults and debounce state encoding for the interrupt front end
package irq_front_pkg;

  localparam int N_SRC_DEF           = 3;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/irq_debounce.sv
// rtl/irq_debounce.sv - one button channel: synchroniser, debounce FSM and rising-edge press strobe
module irq_debounce import irq_front_pkg::*; #(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // press is combinational here; the top registers it into brk on the same edge the FSM enters HIGH
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = RISE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RISE_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!btn_sync) begin
          state_d = FALL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      FALL_WAIT: begin
        if (btn_sync) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/irq_front_end.sv
// rtl/irq_front_end.sv - debounced button interrupts with pending/lost tracking and priority encode
module irq_front_end import irq_front_pkg::*; #(
  parameter int N_SRC           = N_SRC_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           btn_raw,
  input  logic [N_SRC-1:0]           mask,
  input  logic [N_SRC-1:0]           ack,
  input  logic                       clear_lost,
  output logic [N_SRC-1:0]           brk,
  output logic [N_SRC-1:0]           pending,
  output logic [N_SRC-1:0]           lost,
  output logic                       irq_any,
  output logic [$clog2(N_SRC+1)-1:0] top_id
);

  localparam int ID_W = $clog2(N_SRC + 1);

  logic [N_SRC-1:0] press;
  logic [N_SRC-1:0] press_en;

  for (genvar i = 0; i < N_SRC; i++) begin : gen_ch
    irq_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .press  (press[i])
    );
  end

  assign press_en = press & mask;

  // A press alongside ack keeps the request alive and is not counted as lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk     <= '0;
      pending <= '0;
      lost    <= '0;
    end else begin
      brk     <= press_en;
      pending <= press_en | (pending & ~ack);
      lost    <= clear_lost ? '0 : (lost | (press_en & pending & ~ack));
    end
  end

  always_comb begin
    top_id = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if (pending[j]) top_id = ID_W'(j + 1);
    end
  end

  assign irq_any = |pending;

endmodule

// File: tb/tb_irq_front_end.sv
// tb/tb_irq_front_end.sv - directed self-checking bench for irq_front_end
module tb_irq_front_end;

  logic       clk;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] mask;
  logic [2:0] ack;
  logic       clear_lost;
  logic [2:0] brk;
  logic [2:0] pending;
  logic [2:0] lost;
  logic       irq_any;
  logic [1:0] top_id;

  int total = 0;
  int bad   = 0;

  irq_front_end dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .mask      (mask),
    .ack       (ack),
    .clear_lost(clear_lost),
    .brk       (brk),
    .pending   (pending),
    .lost      (lost),
    .irq_any   (irq_any),
    .top_id    (top_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_raw = '0; mask = 3'b111; ack = '0; clear_lost = 1'b0;
    idle(3);
    total++; if (brk !== 3'b000)     begin bad++; $display("FAIL reset_brk: got %b want 000", brk); end
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL reset_pending: got %b want 000", pending); end
    total++; if (lost !== 3'b000)    begin bad++; $display("FAIL reset_lost: got %b want 000", lost); end
    total++; if (irq_any !== 1'b0)   begin bad++; $display("FAIL reset_irq_any: got %b want 0", irq_any); end
    total++; if (top_id !== 2'd0)    begin bad++; $display("FAIL reset_top_id: got %0d want 0", top_id); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_clean_press();
    int first, hi;
    first = 0; hi = 0;
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (brk[0]) begin hi++; if (first == 0) first = c; end
    end
    total++; if (first !== 18) begin bad++; $display("FAIL clean_latency: got %0d want 18", first); end
    total++; if (hi !== 1)     begin bad++; $display("FAIL clean_pulse_width: got %0d want 1", hi); end
    total++; if (pending !== 3'b001) begin bad++; $display("FAIL clean_pending: got %b want 001", pending); end
    total++; if (top_id !== 2'd1)    begin bad++; $display("FAIL clean_top_id: got %0d want 1", top_id); end
    total++; if (irq_any !== 1'b1)   begin bad++; $display("FAIL clean_irq_any: got %b want 1", irq_any); end
    btn_raw[0] = 1'b0;
    hi = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (brk[0]) hi++;
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL release_no_pulse: got %0d want 0", hi); end
    ack = 3'b001; step(); ack = '0;
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL clean_ack: got %b want 000", pending); end
    total++; if (top_id !== 2'd0)    begin bad++; $display("FAIL clean_ack_top_id: got %0d want 0", top_id); end
  endtask

  task automatic test_bounce();
    int first, hi, hi_bounce;
    first = 0; hi = 0; hi_bounce = 0;
    for (int k = 0; k < 40; k++) begin
      btn_raw[1] = ((k / 3) % 2) == 0;
      step();
      if (brk[1]) hi_bounce++;
    end
    btn_raw[1] = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (brk[1]) begin hi++; if (first == 0) first = c; end
    end
    total++; if (hi_bounce !== 0) begin bad++; $display("FAIL bounce_spurious: got %0d want 0", hi_bounce); end
    total++; if (first !== 18)    begin bad++; $display("FAIL bounce_latency: got %0d want 18", first); end
    total++; if (hi !== 1)        begin bad++; $display("FAIL bounce_count: got %0d want 1", hi); end
    btn_raw[1] = 1'b0;
    ack = 3'b010; step(); ack = '0;
    idle(40);
  endtask

  task automatic test_glitch();
    int hi;
    hi = 0;
    btn_raw[1] = 1'b1;
    idle(15);
    btn_raw[1] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (brk[1]) hi++;
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL glitch15: got %0d pulses want 0", hi); end
    total++; if (pending[1] !== 1'b0) begin bad++; $display("FAIL glitch15_pending: got %b want 0", pending[1]); end
    hi = 0;
    btn_raw[1] = 1'b1;
    idle(16);
    btn_raw[1] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (brk[1]) hi++;
    end
    total++; if (hi !== 1) begin bad++; $display("FAIL glitch16: got %0d pulses want 1", hi); end
    ack = 3'b010; step(); ack = '0;
    idle(30);
  endtask

  task automatic test_lost();
    btn_raw[2] = 1'b1; idle(20);
    btn_raw[2] = 1'b0; idle(20);
    total++; if (pending !== 3'b100) begin bad++; $display("FAIL lost_first_pending: got %b want 100", pending); end
    total++; if (lost !== 3'b000)    begin bad++; $display("FAIL lost_first_lost: got %b want 000", lost); end
    btn_raw[2] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 17) begin
        total++; if (lost[2] !== 1'b0) begin bad++; $display("FAIL lost_early: got %b want 0", lost[2]); end
      end
      if (c == 18) begin
        total++; if (lost[2] !== 1'b1) begin bad++; $display("FAIL lost_set_edge: got %b want 1", lost[2]); end
      end
    end
    btn_raw[2] = 1'b0; idle(30);
    total++; if (pending !== 3'b100) begin bad++; $display("FAIL lost_pending_held: got %b want 100", pending); end
    clear_lost = 1'b1; step(); clear_lost = 1'b0;
    total++; if (lost !== 3'b000)    begin bad++; $display("FAIL clear_lost: got %b want 000", lost); end
    total++; if (pending !== 3'b100) begin bad++; $display("FAIL clear_lost_pending: got %b want 100", pending); end
    btn_raw[2] = 1'b1;
    idle(17);
    clear_lost = 1'b1; step(); clear_lost = 1'b0;
    total++; if (brk[2] !== 1'b1)  begin bad++; $display("FAIL clear_vs_set_brk: got %b want 1", brk[2]); end
    total++; if (lost[2] !== 1'b0) begin bad++; $display("FAIL clear_vs_set_lost: got %b want 0", lost[2]); end
    btn_raw[2] = 1'b0;
    ack = 3'b100; step(); ack = '0;
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL lost_ack: got %b want 000", pending); end
    idle(40);
  endtask

  task automatic test_ack_press();
    btn_raw[0] = 1'b1; idle(20);
    btn_raw[0] = 1'b0; idle(30);
    btn_raw[0] = 1'b1;
    idle(17);
    ack = 3'b001; step(); ack = '0;
    total++; if (brk[0] !== 1'b1)     begin bad++; $display("FAIL ackpress_brk: got %b want 1", brk[0]); end
    total++; if (pending[0] !== 1'b1) begin bad++; $display("FAIL ackpress_pending: got %b want 1", pending[0]); end
    total++; if (lost[0] !== 1'b0)    begin bad++; $display("FAIL ackpress_lost: got %b want 0", lost[0]); end
    btn_raw[0] = 1'b0;
    ack = 3'b001; step(); ack = '0;
    idle(40);
  endtask

  task automatic test_mask_priority();
    int hi;
    hi = 0;
    mask = 3'b101;
    btn_raw[1] = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (brk[1]) hi++;
    end
    total++; if (hi !== 0)            begin bad++; $display("FAIL mask_brk: got %0d pulses want 0", hi); end
    total++; if (pending !== 3'b000)  begin bad++; $display("FAIL mask_pending: got %b want 000", pending); end
    total++; if (lost !== 3'b000)     begin bad++; $display("FAIL mask_lost: got %b want 000", lost); end
    btn_raw[1] = 1'b0; idle(30);
    mask = 3'b111;
    btn_raw = 3'b101; idle(25);
    total++; if (pending !== 3'b101) begin bad++; $display("FAIL prio_pending: got %b want 101", pending); end
    total++; if (top_id !== 2'd3)    begin bad++; $display("FAIL prio_top3: got %0d want 3", top_id); end
    ack = 3'b100; step(); ack = '0;
    total++; if (top_id !== 2'd1)    begin bad++; $display("FAIL prio_after_ack2: got %0d want 1", top_id); end
    total++; if (pending !== 3'b001) begin bad++; $display("FAIL prio_pending_after_ack2: got %b want 001", pending); end
    ack = 3'b011; step(); ack = '0;
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL prio_ack_idle_src: got %b want 000", pending); end
    total++; if (irq_any !== 1'b0)   begin bad++; $display("FAIL prio_irq_any: got %b want 0", irq_any); end
    btn_raw = '0; idle(40);
  endtask

  task automatic test_reset_mid();
    int first0, first2, hi0, hi2;
    first0 = 0; first2 = 0; hi0 = 0; hi2 = 0;
    btn_raw[2] = 1'b1; idle(25);
    total++; if (pending !== 3'b100) begin bad++; $display("FAIL rmid_pre_pending: got %b want 100", pending); end
    btn_raw[0] = 1'b1; idle(10);
    rst = 1'b1;
    #2;
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL rmid_pending: got %b want 000", pending); end
    total++; if (top_id !== 2'd0)    begin bad++; $display("FAIL rmid_top_id: got %0d want 0", top_id); end
    total++; if (irq_any !== 1'b0)   begin bad++; $display("FAIL rmid_irq_any: got %b want 0", irq_any); end
    idle(3);
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (brk[0]) begin hi0++; if (first0 == 0) first0 = c; end
      if (brk[2]) begin hi2++; if (first2 == 0) first2 = c; end
    end
    total++; if (first0 !== 18) begin bad++; $display("FAIL rmid_latency0: got %0d want 18", first0); end
    total++; if (hi0 !== 1)     begin bad++; $display("FAIL rmid_count0: got %0d want 1", hi0); end
    total++; if (first2 !== 18) begin bad++; $display("FAIL rmid_latency2: got %0d want 18", first2); end
    total++; if (hi2 !== 1)     begin bad++; $display("FAIL rmid_count2: got %0d want 1", hi2); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_lost();
    test_ack_press();
    test_mask_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
